div_result_bcd: RTL
===================

// Module: div_result_bcd
// PURPOSE
//   Downstream stage of the 16-bit signed divider. Takes one signed quotient or
//   remainder word and converts it to sign plus packed BCD digits using
//   sequential double-dabble (shift-add-3), one bit per clock.
//   Output feeds the seven-segment/UART display path.
//   Input and output each use a valid/ready handshake.
// PARAMETERS
//   WIDTH    16  input word width, two's complement
//   DIGITS   5   BCD digits out; must satisfy 10^DIGITS > 2^(WIDTH-1)
// PORTS
//   sys_clk    in   1           system clock, all logic on rising edge
//   sys_rst    in   1           synchronous reset, active-high
//   in_data    in   WIDTH       signed value to convert (divider Quo or Rem)
//   in_valid   in   1           in_data valid
//   in_ready   out  1           block can accept; high only in IDLE
//   out_sign   out  1           1 = value was negative
//   out_bcd    out  4*DIGITS    packed BCD; [3:0] = ones digit, MS digit at top
//   out_valid  out  1           result valid; held until out_ready
//   out_ready  in   1           consumer accepts result
//   busy       out  1           high in CONV or DONE
// BEHAVIOUR
// - Clock and reset: one clock, sys_clk. Reset is synchronous and active-high.
//   While sys_rst is sampled high: state=IDLE, in_ready=1, out_valid=0,
//   out_sign=0, out_bcd=0, busy=0, iteration counter=0.
//   Reset mid-CONV or mid-DONE discards the word; no partial result appears.
// - FSM states: IDLE -> CONV -> DONE -> IDLE.
// - IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready at edge k: latch sign = in_data[WIDTH-1].
//   - Latch magnitude = sign ? (0 - in_data) : in_data, as a WIDTH-bit
//     unsigned value. The most negative input gives 2^(WIDTH-1) exactly
//     (-32768 -> 32768); it does not overflow.
//   - Clear the BCD accumulator. Go to CONV with counter=0.
// - CONV (WIDTH cycles):
//   - Each cycle, first add 3 to every accumulator digit >= 5.
//   - Then shift {bcd_acc, mag} left by 1 (mag MSB enters bcd_acc[0]).
//   - Counter increments each cycle. After the cycle with counter==WIDTH-1,
//     go to DONE.
//   - in_ready=0. in_valid is ignored.
// - DONE:
//   - out_valid=1. out_sign and out_bcd are registered and stable until the
//     handshake.
//   - On out_valid&&out_ready: out_valid drops next cycle and state goes to IDLE.
//   - in_ready rises one cycle after the output handshake. An input is never
//     accepted in the same cycle as the output handshake.
// - Latency: accept at edge k; out_valid is high after edge k+WIDTH+1
//   (17 edges for WIDTH=16).
// - Throughput: at most one conversion per WIDTH+2 cycles.
// - Zero input: out_sign=0 and all digits 0. Negative zero cannot occur.
// - out_bcd holds the last result after the handshake; it is only updated on
//   the next entry to DONE.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     - In DONE, each leading-zero digit above the ones digit is replaced by 4'hF
//       (display blank code).
//     - The ones digit is never blanked.
//     - out_sign is unchanged.
//   LEADING_ZERO_BLANK_EN undefined:
//     - Leading zeros are output as 4'h0.
//     - No blanking logic is synthesised.
// TESTING
//   1) in_data=16'd1234 -> out_sign=0, out_bcd=20'h01234 (blank build: 20'hF1234);
//      out_valid exactly 17 edges after accept.
//   2) in_data=16'h8000 (-32768) -> out_sign=1, out_bcd=20'h32768.
//   3) in_data=16'hFFFF (-1) -> out_sign=1, out_bcd=20'h00001 (blank: 20'hFFFF1).
//      in_data=0 -> out_sign=0, out_bcd=20'h00000 (blank: 20'hFFFF0).
//   4) Backpressure: hold out_ready=0 for 10 cycles after out_valid
//      -> out_valid, out_sign and out_bcd stable, in_ready=0 throughout.
//      in_valid pulses during CONV/DONE are not accepted.
//   5) Assert sys_rst at CONV counter=7 -> next cycle: IDLE, in_ready=1,
//      out_valid=0, out_bcd=0. A following input 16'd32767 -> out_bcd=20'h32767.
//   6) Back-to-back stream 100, -250, 9999 with out_ready=1
//      -> results 00100/+, 00250/-, 09999/+ in order, each in a separate
//      DONE phase.

Source files
------------

// File: rtl/div_result_bcd.sv
// div_result_bcd: signed word to sign + packed BCD via sequential double-dabble, one bit per clock.
// Optional LEADING_ZERO_BLANK_EN replaces leading-zero digits (except the ones digit) with 4'hF.
module div_result_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_sign,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mag;
    logic [4*DIGITS-1:0] acc, adj, disp;
    logic sign;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = in_valid ? CONV : IDLE;
            CONV: state_nx = (cnt == CW'(WIDTH-1)) ? DONE : CONV;
            DONE: state_nx = (out_valid && out_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        in_ready = (state == IDLE);
        busy = (state != IDLE);
    end
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign adj[4*d+:4] = (acc[4*d+:4] >= 4'd5) ? acc[4*d+:4] + 4'd3 : acc[4*d+:4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        lead = 1'b1;
        disp = acc;
        for (int i = DIGITS-1; i > 0; i--) begin
            lead = lead && (acc[4*i+:4] == 4'd0);
            if (lead) disp[4*i+:4] = 4'hF;
        end
    end
`else
    assign disp = acc;
`endif
    // The first DONE cycle registers the result; out_valid rises with it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mag       <= '0;
            acc       <= '0;
            sign      <= 1'b0;
            out_sign  <= 1'b0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    sign <= in_data[WIDTH-1];
                    mag  <= in_data[WIDTH-1] ? -in_data : in_data;
                    acc  <= '0;
                    cnt  <= '0;
                end
                CONV: begin
                    {acc, mag} <= {adj, mag} << 1;
                    cnt <= cnt + CW'(1);
                end
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_bcd   <= disp;
                    out_sign  <= sign;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
